multdiv_issue: RTL

- Processor-side initiator for the shared multiply/divide unit.
- Accepts a decoded MULT or DIV instruction from the execute stage and registers its operands.
- Issues a single-cycle ctrl_MULT/ctrl_DIV pulse, stalls the pipeline, and waits for data_resultRDY.
- Then presents one writeback request: the result to rd, or the status code to the status register on exception.

---
 rtl/multdiv_issue_pkg.sv | 19 +
 rtl/multdiv_timeout_counter.sv | 33 +++
 rtl/multdiv_issue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_pkg.sv
// Shared definitions for the multiply/divide issue block.
// Holds the issue FSM state encoding and the default status codes and
// status register index written back when the multdiv unit reports an
// exception.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam int          DEF_TIMEOUT_CYCLES = 64;
  localparam logic [31:0] DEF_MULT_STATUS    = 32'd4;
  localparam logic [31:0] DEF_DIV_STATUS     = 32'd5;
  localparam logic [4:0]  DEF_STATUS_REG     = 5'd30;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Cycle counter bounding how long the issue FSM waits for the multdiv unit.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   i_clr    synchronous clear (dominates enable)
//   i_en     count enable
//   o_tc     terminal count: counter equals TIMEOUT_CYCLES-1
module multdiv_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/multdiv_issue.sv
// Processor-side initiator for the shared multiply/divide unit.
// Latches a MULT/DIV from execute, pulses the unit's start control for one
// cycle, stalls the pipeline until data_resultRDY, then issues a single
// writeback: the result to rd, or a status code to STATUS_REG on exception.
// A wait longer than TIMEOUT_CYCLES aborts the op and sets sticky md_timeout.
// Ports:
//   clock, reset                   clock / synchronous active-high reset
//   issue_mult, issue_div          op presented by execute (MULT wins ties)
//   issue_rd, op_a, op_b           destination and operands of that op
//   md_ctrl_MULT, md_ctrl_DIV      one-cycle start pulses to the unit
//   md_operandA, md_operandB       latched operands, held during the op
//   md_result, md_exception,
//   md_resultRDY                   unit response
//   stall                          freeze fetch/decode/execute
//   wb_valid, wb_rd, wb_data       one-cycle writeback request
//   md_timeout                     sticky abort-by-timeout flag
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] MULT_STATUS    = DEF_MULT_STATUS,
  parameter logic [31:0] DIV_STATUS     = DEF_DIV_STATUS,
  parameter logic [4:0]  STATUS_REG     = DEF_STATUS_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        md_timeout
);

  state_t      r_state;
  state_t      w_next;
  logic        w_issue;
  logic        w_tc;
  logic        w_accept;
  logic        w_done;
  logic        w_abort;

  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_rd;
  logic        r_is_div;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_timeout;

  assign w_issue  = issue_mult | issue_div;
  assign w_accept = (r_state == ST_IDLE) && w_issue;
  // RDY is only meaningful in WAIT; in START it is still left over from the
  // previous operation.
  assign w_done   = (r_state == ST_WAIT) && md_resultRDY;
  assign w_abort  = (r_state == ST_WAIT) && !md_resultRDY && w_tc;

  // Counter runs only while waiting and restarts from zero on each op.
  multdiv_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock (clock),
    .i_reset (reset),
    .i_clr   (r_state != ST_WAIT),
    .i_en    (r_state == ST_WAIT),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_issue) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT: begin
        if (md_resultRDY) begin
          w_next = ST_WB;
        end else if (w_tc) begin
          w_next = ST_IDLE;
        end
      end
      ST_WB:    w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_is_div  <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a   <= op_a;
        r_op_b   <= op_b;
        r_rd     <= issue_rd;
        r_is_div <= ~issue_mult;
      end
      if (w_done) begin
        r_result <= md_result;
        r_exc    <= md_exception;
      end
      if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    case (r_state)
      ST_IDLE:  stall = w_issue;
      ST_START: begin
        stall        = 1'b1;
        md_ctrl_MULT = ~r_is_div;
        md_ctrl_DIV  = r_is_div;
      end
      ST_WAIT:  stall = 1'b1;
      ST_WB: begin
        if (r_exc) begin
          wb_valid = 1'b1;
          wb_rd    = STATUS_REG;
          wb_data  = r_is_div ? DIV_STATUS : MULT_STATUS;
        end else begin
          // Writes to r0 are dropped.
          wb_valid = (r_rd != 5'd0);
          wb_rd    = r_rd;
          wb_data  = r_result;
        end
      end
      default: ;
    endcase
  end

  assign md_operandA = r_op_a;
  assign md_operandB = r_op_b;
  assign md_timeout  = r_timeout;

endmodule
